xdma_c2h_pkt_buf: RTL

XDMA_C2H_PKT_BUF -- requirements
Module: xdma_c2h_pkt_buf

---
 rtl/xdma_c2h_pkt_buf_pkg.sv | 19 +
 rtl/xdma_c2h_pkt_ram.sv | 27 ++
 rtl/xdma_c2h_pkt_buf.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/xdma_c2h_pkt_buf_pkg.sv
// rtl/xdma_c2h_pkt_buf_pkg.sv - shared types, default widths and pointer helper for the C2H packet buffer
package xdma_c2h_pkt_buf_pkg;

  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_KEEP_WIDTH = 64;
  localparam int DEF_USER_WIDTH = 1;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

  // One extra pointer bit distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/xdma_c2h_pkt_ram.sv
// rtl/xdma_c2h_pkt_ram.sv - simple dual-port beat RAM with registered read
module xdma_c2h_pkt_ram #(
  parameter int WIDTH = 577,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; rd_data holds when rd_en is low so it can act as the output register.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/xdma_c2h_pkt_buf.sv
// rtl/xdma_c2h_pkt_buf.sv - store-and-forward C2H packet buffer with drop-on-overflow/error
module xdma_c2h_pkt_buf
  import xdma_c2h_pkt_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH,
  parameter int USER_WIDTH = DEF_USER_WIDTH,
  parameter int DEPTH      = 64
) (
  input  logic                          xdma_clk,
  input  logic                          xdma_reset,
  input  logic                          udp_rx_axis_tvalid,
  output logic                          udp_rx_axis_tready,
  input  logic                          udp_rx_axis_tlast,
  input  logic [DATA_WIDTH-1:0]         udp_rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         udp_rx_axis_tkeep,
  input  logic [USER_WIDTH-1:0]         udp_rx_axis_tuser,
  output logic                          xdma_rx_axis_tvalid,
  input  logic                          xdma_rx_axis_tready,
  output logic                          xdma_rx_axis_tlast,
  output logic [DATA_WIDTH-1:0]         xdma_rx_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         xdma_rx_axis_tkeep,
  output logic [USER_WIDTH-1:0]         xdma_rx_axis_tuser,
  output logic [31:0]                   pkt_cnt,
  output logic [31:0]                   drop_cnt,
  output logic [ptr_width(DEPTH)-1:0]   fill_level
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;

  wr_state_t     state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, commit_ptr, commit_ptr_nxt, rd_ptr, rd_next;
  logic          accept, full, ram_we, pkt_inc, drop_inc;
  logic          out_valid, handshake, rd_en;
  logic [EW-1:0] rd_data;

  // Upstream is never stalled; only reset deasserts ready.
  assign udp_rx_axis_tready = xdma_reset;
  assign accept             = udp_rx_axis_tvalid & xdma_reset;
  assign full               = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign fill_level         = wr_ptr - rd_ptr;

  // Write FSM next state: store, commit on good tlast, rewind on error/overflow.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    ram_we         = 1'b0;
    pkt_inc        = 1'b0;
    drop_inc       = 1'b0;
    case (state)
      WR_IDLE, WR_WRITE: begin
        if (accept) begin
          if (full) begin
            wr_ptr_nxt = commit_ptr;
            if (udp_rx_axis_tlast) begin
              state_nxt = WR_IDLE;
              drop_inc  = 1'b1;
            end else begin
              state_nxt = WR_DROP;
            end
          end else begin
            ram_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            if (!udp_rx_axis_tlast) begin
              state_nxt = WR_WRITE;
            end else if (udp_rx_axis_tuser[0]) begin
              wr_ptr_nxt = commit_ptr;
              drop_inc   = 1'b1;
              state_nxt  = WR_IDLE;
            end else begin
              commit_ptr_nxt = wr_ptr + PW'(1);
              pkt_inc        = 1'b1;
              state_nxt      = WR_IDLE;
            end
          end
        end
      end
      WR_DROP: begin
        if (accept && udp_rx_axis_tlast) begin
          state_nxt = WR_IDLE;
          drop_inc  = 1'b1;
        end
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  // Write-side state, pointers and saturating counters.
  always_ff @(posedge xdma_clk) begin
    if (!xdma_reset) begin
      state      <= WR_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      if (pkt_inc && (pkt_cnt != 32'hFFFF_FFFF))   pkt_cnt  <= pkt_cnt + 32'd1;
      if (drop_inc && (drop_cnt != 32'hFFFF_FFFF)) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // rd_ptr points at the beat held in the output register, so that beat still occupies space.
  assign handshake = out_valid & xdma_rx_axis_tready;
  assign rd_next   = handshake ? (rd_ptr + PW'(1)) : rd_ptr;
  assign rd_en     = (rd_next != commit_ptr) && (!out_valid || xdma_rx_axis_tready);

  // Read side: prefetch the next committed beat whenever the output register is free or draining.
  always_ff @(posedge xdma_clk) begin
    if (!xdma_reset) begin
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      if (rd_en)                    out_valid <= 1'b1;
      else if (xdma_rx_axis_tready) out_valid <= 1'b0;
    end
  end

  xdma_c2h_pkt_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (xdma_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({udp_rx_axis_tdata, udp_rx_axis_tkeep, udp_rx_axis_tlast}),
    .rd_en   (rd_en),
    .rd_addr (rd_next[AW-1:0]),
    .rd_data (rd_data)
  );

  assign xdma_rx_axis_tvalid = out_valid;
  assign xdma_rx_axis_tdata  = rd_data[EW-1 -: DATA_WIDTH];
  assign xdma_rx_axis_tkeep  = rd_data[KEEP_WIDTH:1];
  assign xdma_rx_axis_tlast  = rd_data[0];
  assign xdma_rx_axis_tuser  = '0;

endmodule
